fp16_sqrt_host: RTL and testbench
=================================

# fp16_sqrt_host

Bus-side initiator for the half-precision square-root core. It accepts an FP16 operand on a valid/ready request port and drives it onto the shared bidirectional `IO_DATA` bus while asserting `ENABLE`. It then turns the bus around, waits for the core's `RESULT` strobe, and captures the result word and status flags. Results are presented on a valid/ready response port. It sits between the system datapath and the sqrt core and owns all bus direction control on the host side.

## Interface
- `TIMEOUT_CYCLES`, 255: maximum WAIT cycles before abort; range 1..65535; used only with the timeout feature.
- `CLK` in 1: single clock; all logic on posedge.
- `RESET` in 1: synchronous, active-high.
- `REQ_VALID` in 1: operand request valid.
- `REQ_READY` out 1: host idle, can accept.
- `REQ_DATA` in 16: FP16 operand.
- `RSP_VALID` out 1: response valid.
- `RSP_READY` in 1: downstream accepts response.
- `RSP_DATA` out 16: captured FP16 result.
- `RSP_NAN`, `RSP_PINF`, `RSP_NINF` out 1 each: captured core flags.
- `RSP_TIMEOUT` out 1: transaction aborted by watchdog.
- `IO_DATA` inout 16: shared bus; host drives only in DRIVE, else 16'hZZZZ.
- `ENABLE` out 1: core enable.
- `RESULT` in 1: core result strobe.
- `IS_NAN`, `IS_PINF`, `IS_NINF` in 1 each: core flags, valid with `RESULT`.

## Operation
- States: IDLE, DRIVE, TURN, WAIT, RESP.
- IDLE:
  - `REQ_READY`=1, `ENABLE`=0, bus released.
  - On `REQ_VALID`&`REQ_READY`, latch `REQ_DATA` into the operand register and go to DRIVE.
- DRIVE (exactly 1 cycle):
  - `ENABLE`=1; `IO_DATA`=operand.
  - Core samples on the closing edge.
  - Go to TURN.
- TURN (exactly 1 cycle):
  - `ENABLE`=1; bus released.
  - This is the turnaround cycle; the core is not permitted to drive before the following cycle.
  - Go to WAIT.
- WAIT:
  - `ENABLE`=1; bus released.
  - On a sampled `RESULT`=1:
    - Capture `IO_DATA` into `RSP_DATA` and `IS_NAN/IS_PINF/IS_NINF` into `RSP_*`; clear `RSP_TIMEOUT`.
    - Go to RESP.
  - While `RESULT`=0, remain in WAIT.
- RESP:
  - `ENABLE`=0, bus released, `RSP_VALID`=1.
  - Response outputs are held stable until `RSP_VALID`&`RSP_READY`, then go to IDLE.
  - `ENABLE` is low for at least one full cycle (RESP plus IDLE) between transactions so the core's internal count restarts.
- Bus rule: host output-enable is high only in DRIVE; never concurrent with any cycle in which `RESULT` may be asserted.
- Host performs no FP arithmetic and no special-case decoding; result data and flags are passed through unmodified.
- `RESULT` high outside WAIT is ignored.

## Timing
- Reset values:
  - State IDLE.
  - `ENABLE`=0, `IO_DATA`=Z.
  - `REQ_READY`=1 (from the first cycle after reset), `RSP_VALID`=0.
  - `RSP_DATA`=16'h0000; all `RSP_*` flags 0; watchdog counter 0.
- Request accept edge is cycle 0. DRIVE is cycle 1, TURN is cycle 2, WAIT starts at cycle 3.
- If `RESULT` is high in cycle N (N≥3), `RSP_VALID`=1 in cycle N+1.
- Minimum request-to-response latency: 4 cycles.
- Minimum issue interval: 5 cycles, with `RSP_READY` tied high.
- `REQ_READY` is 0 in every state except IDLE; no request queuing.
- RESET mid-transaction:
  - Next cycle is IDLE with reset values.
  - Bus released and `ENABLE` dropped immediately on that edge.
  - Any in-flight response is discarded.

## Configuration
- Macro: `FP16_SQRT_HOST_TIMEOUT_EN`.
- Defined:
  - A 16-bit watchdog counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT_CYCLES` with `RESULT` still 0, go to RESP with `RSP_DATA`=16'hFE00, `RSP_TIMEOUT`=1, and all other flags 0.
  - `RESULT` in the same cycle as expiry takes priority: normal capture, no timeout.
- Undefined:
  - WAIT is unbounded.
  - `RSP_TIMEOUT` is tied to 0.
  - `TIMEOUT_CYCLES` is unused.

## Test plan
- Request 16'h4400 (4.0); core model asserts `RESULT` with 16'h4000 three cycles into WAIT → `RSP_DATA`=16'h4000, flags 0, `RSP_VALID` at cycle 7; bus Z except cycle 1.
- Request 16'hBC00 (−1.0); core returns 16'hFE00 with `IS_NAN`=1 → `RSP_DATA`=16'hFE00, `RSP_NAN`=1.
- Request 16'h7C00 (+Inf); core returns 16'h7C00 with `IS_PINF`=1 → `RSP_PINF`=1. `RSP_READY` held low 10 cycles → `RSP_VALID` and data stable, `REQ_READY`=0, `ENABLE`=0 throughout.
- Back-to-back requests with `RSP_READY`=1 → `ENABLE` low ≥1 cycle between them; a bus-contention checker (host OE & core drive) never fires.
- With `FP16_SQRT_HOST_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, core silent → response after 8 WAIT cycles: 16'hFE00, `RSP_TIMEOUT`=1.
- `RESET` pulsed in WAIT → next cycle IDLE, `ENABLE`=0, bus Z, `RSP_VALID`=0, `REQ_READY`=1; a later `RESULT` pulse produces no response.

Source files
------------

// File: rtl/fp16_sqrt_host.sv
// rtl/fp16_sqrt_host.sv - host-side bus initiator for the FP16 square-root core
// Optional feature macro: FP16_SQRT_HOST_TIMEOUT_EN (WAIT watchdog with forced NaN/timeout response)
module fp16_sqrt_host #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic [15:0] REQ_DATA,
   output logic        RSP_VALID,
   input  logic        RSP_READY,
   output logic [15:0] RSP_DATA,
   output logic        RSP_NAN,
   output logic        RSP_PINF,
   output logic        RSP_NINF,
   output logic        RSP_TIMEOUT,
   inout  wire  [15:0] IO_DATA,
   output logic        ENABLE,
   input  logic        RESULT,
   input  logic        IS_NAN,
   input  logic        IS_PINF,
   input  logic        IS_NINF
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DRIVE = 3'd1,
      S_TURN  = 3'd2,
      S_WAIT  = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        w_host_oe;
   logic        w_req_fire;
   logic        w_capture;
   logic        w_expire;
   logic [15:0] r_operand;
   logic [15:0] r_rsp_data;
   logic        r_rsp_nan;
   logic        r_rsp_pinf;
   logic        r_rsp_ninf;

   // The host only ever drives the shared bus during DRIVE; all other cycles it floats.
   assign IO_DATA = w_host_oe ? r_operand : 16'hZZZZ;

   assign w_req_fire = REQ_VALID && (r_state == S_IDLE);
   assign w_capture  = (r_state == S_WAIT) && RESULT;

   assign RSP_DATA = r_rsp_data;
   assign RSP_NAN  = r_rsp_nan;
   assign RSP_PINF = r_rsp_pinf;
   assign RSP_NINF = r_rsp_ninf;

`ifdef FP16_SQRT_HOST_TIMEOUT_EN
   localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT_CYCLES);

   logic [15:0] r_wdog;
   logic [15:0] w_wdog_inc;
   logic        r_rsp_timeout;

   // r_wdog counts WAIT cycles already completed, so the increment is the count including this one.
   assign w_wdog_inc  = r_wdog + 16'd1;
   assign w_expire    = (r_state == S_WAIT) && !RESULT && (w_wdog_inc == LP_TIMEOUT);
   assign RSP_TIMEOUT = r_rsp_timeout;

   // Watchdog: cleared while in TURN so it starts at zero in the first WAIT cycle.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_wdog <= 16'd0;
      end else if (r_state == S_TURN) begin
         r_wdog <= 16'd0;
      end else if (r_state == S_WAIT) begin
         r_wdog <= w_wdog_inc;
      end
   end

   // Timeout flag: set on watchdog abort, cleared by any genuine core result.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_rsp_timeout <= 1'b0;
      end else if (w_capture) begin
         r_rsp_timeout <= 1'b0;
      end else if (w_expire) begin
         r_rsp_timeout <= 1'b1;
      end
   end
`else
   logic w_unused_cfg;

   assign w_expire     = 1'b0;
   assign RSP_TIMEOUT  = 1'b0;
   assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

   // State register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and per-state bus/handshake outputs.
   always_comb begin
      w_next    = r_state;
      REQ_READY = 1'b0;
      RSP_VALID = 1'b0;
      ENABLE    = 1'b0;
      w_host_oe = 1'b0;
      case (r_state)
         S_IDLE: begin
            REQ_READY = 1'b1;
            if (REQ_VALID) begin
               w_next = S_DRIVE;
            end
         end
         S_DRIVE: begin
            ENABLE    = 1'b1;
            w_host_oe = 1'b1;
            w_next    = S_TURN;
         end
         S_TURN: begin
            ENABLE = 1'b1;
            w_next = S_WAIT;
         end
         S_WAIT: begin
            ENABLE = 1'b1;
            if (RESULT || w_expire) begin
               w_next = S_RESP;
            end
         end
         S_RESP: begin
            RSP_VALID = 1'b1;
            if (RSP_READY) begin
               w_next = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Operand latch on request acceptance.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_operand <= 16'h0000;
      end else if (w_req_fire) begin
         r_operand <= REQ_DATA;
      end
   end

   // Response capture: core word and flags pass through untouched; a watchdog abort forces NaN.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_rsp_data <= 16'h0000;
         r_rsp_nan  <= 1'b0;
         r_rsp_pinf <= 1'b0;
         r_rsp_ninf <= 1'b0;
      end else if (w_capture) begin
         r_rsp_data <= IO_DATA;
         r_rsp_nan  <= IS_NAN;
         r_rsp_pinf <= IS_PINF;
         r_rsp_ninf <= IS_NINF;
      end else if (w_expire) begin
         r_rsp_data <= 16'hFE00;
         r_rsp_nan  <= 1'b0;
         r_rsp_pinf <= 1'b0;
         r_rsp_ninf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fp16_sqrt_host.sv
// tb/tb_fp16_sqrt_host.sv - self-checking bench for fp16_sqrt_host
module tb_fp16_sqrt_host;

`ifdef FP16_SQRT_HOST_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 255;
`endif

   logic        CLK = 1'b0;
   logic        RESET;
   logic        REQ_VALID;
   logic        REQ_READY;
   logic [15:0] REQ_DATA;
   logic        RSP_VALID;
   logic        RSP_READY;
   logic [15:0] RSP_DATA;
   logic        RSP_NAN, RSP_PINF, RSP_NINF, RSP_TIMEOUT;
   wire  [15:0] IO_DATA;
   logic        ENABLE;
   logic        RESULT;
   logic        IS_NAN, IS_PINF, IS_NINF;

   logic        core_oe;
   logic [15:0] core_data;

   int n_checks = 0;
   int n_fail   = 0;

   // core side of the shared bus
   assign IO_DATA = core_oe ? core_data : 16'hZZZZ;

   fp16_sqrt_host #(.TIMEOUT_CYCLES(TO)) dut (
      .CLK(CLK), .RESET(RESET),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_DATA(REQ_DATA),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
      .RSP_NAN(RSP_NAN), .RSP_PINF(RSP_PINF), .RSP_NINF(RSP_NINF), .RSP_TIMEOUT(RSP_TIMEOUT),
      .IO_DATA(IO_DATA), .ENABLE(ENABLE), .RESULT(RESULT),
      .IS_NAN(IS_NAN), .IS_PINF(IS_PINF), .IS_NINF(IS_NINF)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // transaction-level model: a request is in flight from acceptance until the result
   // (or watchdog), then a response is pending until accepted downstream
   logic        m_started = 1'b0;
   int          m_cyc = 0;
   int          m_acc = 0;
   logic        m_busy = 1'b0;
   logic        m_pend = 1'b0;
   logic [15:0] m_op = 16'h0;
   logic [15:0] m_data = 16'h0;
   logic [2:0]  m_flags = 3'b0;
   logic        m_to = 1'b0;

   always @(posedge CLK) begin
      m_started <= 1'b1;
      m_cyc     <= m_cyc + 1;
      if (RESET) begin
         m_busy  <= 1'b0;
         m_pend  <= 1'b0;
         m_data  <= 16'h0;
         m_flags <= 3'b0;
         m_to    <= 1'b0;
      end else if (m_busy) begin
         if (m_cyc >= m_acc + 3) begin
            if (RESULT) begin
               m_busy  <= 1'b0;
               m_pend  <= 1'b1;
               m_data  <= core_data;
               m_flags <= {IS_NAN, IS_PINF, IS_NINF};
               m_to    <= 1'b0;
            end
`ifdef FP16_SQRT_HOST_TIMEOUT_EN
            else if (m_cyc - m_acc - 2 == TO) begin
               m_busy  <= 1'b0;
               m_pend  <= 1'b1;
               m_data  <= 16'hFE00;
               m_flags <= 3'b0;
               m_to    <= 1'b1;
            end
`endif
         end
      end else if (m_pend) begin
         if (RSP_READY) m_pend <= 1'b0;
      end else if (REQ_VALID) begin
         m_busy <= 1'b1;
         m_acc  <= m_cyc;
         m_op   <= REQ_DATA;
      end
   end

   // per-cycle comparison against the model
   always @(negedge CLK) begin
      if (m_started) begin
         chk("req_ready", {31'b0, REQ_READY}, {31'b0, !m_busy && !m_pend});
         chk("enable", {31'b0, ENABLE}, {31'b0, m_busy});
         chk("host_oe", {31'b0, dut.w_host_oe}, {31'b0, m_busy && (m_cyc == m_acc + 1)});
         if (m_busy && (m_cyc == m_acc + 1)) chk("bus_operand", {16'b0, IO_DATA}, {16'b0, m_op});
         chk("rsp_valid", {31'b0, RSP_VALID}, {31'b0, m_pend});
         chk("rsp_data", {16'b0, RSP_DATA}, {16'b0, m_data});
         chk("rsp_flags", {29'b0, RSP_NAN, RSP_PINF, RSP_NINF}, {29'b0, m_flags});
         chk("rsp_timeout", {31'b0, RSP_TIMEOUT}, {31'b0, m_to});
         chk("bus_contention", {31'b0, dut.w_host_oe & core_oe}, 32'd0);
      end
   end

   // one request; core answers d cycles into WAIT; downstream stalls for hold cycles
   task automatic txn(input logic [15:0] op, input logic [15:0] res, input logic [2:0] fl,
                      input int d, input int hold);
      int acc;
      acc       = m_cyc;
      REQ_VALID = 1'b1;
      REQ_DATA  = op;
      RSP_READY = (hold == 0);
      @(negedge CLK);
      chk("idle_enable_low", {31'b0, ENABLE}, 32'd0);
      chk("idle_req_ready", {31'b0, REQ_READY}, 32'd1);
      @(posedge CLK); #1;
      REQ_VALID = 1'b0;
      REQ_DATA  = 16'(($urandom));
      repeat (2 + d) @(posedge CLK);
      #1;
      RESULT    = 1'b1;
      core_oe   = 1'b1;
      core_data = res;
      {IS_NAN, IS_PINF, IS_NINF} = fl;
      @(posedge CLK); #1;
      RESULT  = 1'b0;
      core_oe = 1'b0;
      {IS_NAN, IS_PINF, IS_NINF} = 3'b0;
      @(negedge CLK);
      chk("latency", m_cyc - acc, 4 + d);
      chk("rsp_valid_lit", {31'b0, RSP_VALID}, 32'd1);
      chk("rsp_data_lit", {16'b0, RSP_DATA}, {16'b0, res});
      chk("rsp_flags_lit", {29'b0, RSP_NAN, RSP_PINF, RSP_NINF}, {29'b0, fl});
      for (int i = 0; i < hold; i++) begin
         if (i > 0) @(negedge CLK);
         chk("hold_valid", {31'b0, RSP_VALID}, 32'd1);
         chk("hold_data", {16'b0, RSP_DATA}, {16'b0, res});
         chk("hold_enable", {31'b0, ENABLE}, 32'd0);
         chk("hold_req_ready", {31'b0, REQ_READY}, 32'd0);
         @(posedge CLK); #1;
      end
      RSP_READY = 1'b1;
      @(posedge CLK); #1;
   endtask

   initial begin
      RESET = 1'b1; REQ_VALID = 1'b0; REQ_DATA = 16'h0; RSP_READY = 1'b1;
      RESULT = 1'b0; IS_NAN = 1'b0; IS_PINF = 1'b0; IS_NINF = 1'b0;
      core_oe = 1'b0; core_data = 16'h0;
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;
      @(negedge CLK);
      chk("reset_req_ready", {31'b0, REQ_READY}, 32'd1);
      chk("reset_rsp_data", {16'b0, RSP_DATA}, 32'd0);
      @(posedge CLK); #1;

      // sqrt(4.0): result three cycles into WAIT, response at cycle 7
      txn(16'h4400, 16'h4000, 3'b000, 3, 0);
      chk("model_pin_data", {16'b0, m_data}, 32'h4000);
      // sqrt(-1.0) -> NaN
      txn(16'hBC00, 16'hFE00, 3'b100, 1, 0);
      chk("model_pin_nan", {29'b0, m_flags}, 32'd4);
      // sqrt(+Inf) with downstream stall of 10 cycles
      txn(16'h7C00, 16'h7C00, 3'b010, 0, 10);
      // sqrt(-0) passthrough and a NINF-flag passthrough
      txn(16'h8000, 16'h8000, 3'b000, 2, 0);
      txn(16'hFC00, 16'hFC00, 3'b001, 0, 0);
      // back-to-back at minimum interval
      for (int k = 0; k < 4; k++) begin
         txn(16'h3C00 + 16'(k), 16'h3C00 + 16'(k * 3), 3'b000, 0, 0);
      end

`ifdef FP16_SQRT_HOST_TIMEOUT_EN
      // silent core: 8 WAIT cycles (3..10), response in cycle 11
      REQ_VALID = 1'b1; REQ_DATA = 16'h5555;
      @(posedge CLK); #1;
      REQ_VALID = 1'b0;
      repeat (9) @(posedge CLK);
      @(negedge CLK);
      chk("to_not_yet", {31'b0, RSP_VALID}, 32'd0);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("to_valid", {31'b0, RSP_VALID}, 32'd1);
      chk("to_data", {16'b0, RSP_DATA}, 32'hFE00);
      chk("to_flag", {31'b0, RSP_TIMEOUT}, 32'd1);
      @(posedge CLK); #1;
      // RESULT in the expiry cycle wins
      REQ_VALID = 1'b1; REQ_DATA = 16'h4400;
      @(posedge CLK); #1;
      REQ_VALID = 1'b0;
      repeat (9) @(posedge CLK);
      #1;
      RESULT = 1'b1; core_oe = 1'b1; core_data = 16'h3C00;
      @(posedge CLK); #1;
      RESULT = 1'b0; core_oe = 1'b0;
      @(negedge CLK);
      chk("to_prio_data", {16'b0, RSP_DATA}, 32'h3C00);
      chk("to_prio_flag", {31'b0, RSP_TIMEOUT}, 32'd0);
      @(posedge CLK); #1;
`endif

      // reset while in WAIT, then a stray RESULT
      REQ_VALID = 1'b1; REQ_DATA = 16'h4200;
      @(posedge CLK); #1;
      REQ_VALID = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      RESET = 1'b1;
      @(posedge CLK); #1;
      RESET = 1'b0;
      @(negedge CLK);
      chk("rst_enable", {31'b0, ENABLE}, 32'd0);
      chk("rst_oe", {31'b0, dut.w_host_oe}, 32'd0);
      chk("rst_rsp_valid", {31'b0, RSP_VALID}, 32'd0);
      chk("rst_req_ready", {31'b0, REQ_READY}, 32'd1);
      chk("rst_rsp_data", {16'b0, RSP_DATA}, 32'd0);
      @(posedge CLK); #1;
      RESULT = 1'b1; core_oe = 1'b1; core_data = 16'h1234; IS_NAN = 1'b1;
      @(posedge CLK); #1;
      RESULT = 1'b0; core_oe = 1'b0; IS_NAN = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk("stray_result", {31'b0, RSP_VALID}, 32'd0);
      end
      @(posedge CLK); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
